// File: rtl/clk_div_checker_if.sv
// Monitor-side bundle for clk_div_checker: divided clock in, measurements and status out.
interface clk_div_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             clk_div;
  logic             clr_err;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic             period_valid;
  logic             locked;
  logic             err;
  logic [1:0]       err_code;

  modport master (
    output clk_div, clr_err,
    input  high_len, low_len, period_valid, locked, err, err_code
  );

  modport slave (
    input  clk_div, clr_err,
    output high_len, low_len, period_valid, locked, err, err_code
  );
endinterface

// File: rtl/clk_div_checker.sv
// Measures high/low phase lengths of a clk_in-synchronous divided clock and
// checks them against the expected ratio, reporting lock and a sticky error.
module clk_div_checker #(
  parameter int unsigned DIV          = 28,
  parameter int unsigned HIGH_CYC     = 14,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned LOCK_PERIODS = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  clk_div_checker_if.slave  bus
);

  localparam int unsigned GOOD_W = 4;

  localparam logic [CNT_W-1:0]  DIV_C    = CNT_W'(DIV);
  localparam logic [CNT_W-1:0]  HIGH_C   = CNT_W'(HIGH_CYC);
  localparam logic [CNT_W-1:0]  LOW_C    = CNT_W'(DIV - HIGH_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [GOOD_W-1:0] LOCK_C   = GOOD_W'(LOCK_PERIODS);
  localparam logic [GOOD_W-1:0] GOOD_MAX = {GOOD_W{1'b1}};

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_HIGH    = 2'b01;
  localparam logic [1:0] ERR_LOW     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              s0, s1;
  logic              rise_c, fall_c;
  logic              phase_edge_c, timeout_c;

  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_c;
  logic [CNT_W-1:0]  high_len_q, high_len_d;
  logic [CNT_W-1:0]  low_len_q, low_len_d;
  logic              period_valid_q, period_valid_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d, good_inc_c;
  logic              locked_q, locked_d;
  logic              high_ok_q, high_ok_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              new_err_c;
  logic [1:0]        new_code_c;

  // Edge detect on the two-stage sample of clk_div
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= bus.clk_div;
      s1 <= s0;
    end
  end

  assign rise_c = s0 & ~s1;
  assign fall_c = ~s0 & s1;

  // An edge that ends the current phase takes priority over timeout
  assign phase_edge_c = ((state_q == HIGH) && fall_c) || ((state_q == LOW) && rise_c);
  assign timeout_c    = (state_q != IDLE) && !phase_edge_c && (cnt_q >= DIV_C);

  assign cnt_inc_c  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
  assign good_inc_c = (good_cnt_q == GOOD_MAX) ? GOOD_MAX : good_cnt_q + GOOD_W'(1);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (rise_c) state_d = HIGH;
      HIGH: begin
        if (fall_c)         state_d = LOW;
        else if (timeout_c) state_d = IDLE;
      end
      LOW: begin
        if (rise_c)         state_d = HIGH;
        else if (timeout_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Measurement, lock tracking and error classification
  always_comb begin
    cnt_d          = cnt_q;
    high_len_d     = high_len_q;
    low_len_d      = low_len_q;
    period_valid_d = 1'b0;
    good_cnt_d     = good_cnt_q;
    locked_d       = locked_q;
    high_ok_d      = high_ok_q;
    new_err_c      = 1'b0;
    new_code_c     = ERR_NONE;

    unique case (state_q)
      IDLE: begin
        if (rise_c) cnt_d = CNT_ONE;
      end
      HIGH: begin
        if (fall_c) begin
          high_len_d = cnt_q;
          cnt_d      = CNT_ONE;
          high_ok_d  = (cnt_q == HIGH_C);
          if (cnt_q != HIGH_C) begin
            new_err_c  = 1'b1;
            new_code_c = ERR_HIGH;
            good_cnt_d = '0;
            locked_d   = 1'b0;
          end
        end else if (timeout_c) begin
          cnt_d      = '0;
          high_ok_d  = 1'b0;
          new_err_c  = 1'b1;
          new_code_c = ERR_TIMEOUT;
          good_cnt_d = '0;
          locked_d   = 1'b0;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      LOW: begin
        if (rise_c) begin
          low_len_d      = cnt_q;
          period_valid_d = 1'b1;
          cnt_d          = CNT_ONE;
          if (cnt_q != LOW_C) begin
            new_err_c  = 1'b1;
            new_code_c = ERR_LOW;
            good_cnt_d = '0;
            locked_d   = 1'b0;
          end else if (high_ok_q) begin
            good_cnt_d = good_inc_c;
            if (good_inc_c >= LOCK_C) locked_d = 1'b1;
          end else begin
            good_cnt_d = '0;
          end
        end else if (timeout_c) begin
          cnt_d      = '0;
          high_ok_d  = 1'b0;
          new_err_c  = 1'b1;
          new_code_c = ERR_TIMEOUT;
          good_cnt_d = '0;
          locked_d   = 1'b0;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Sticky error: first code is held; a coincident new error beats clr_err
  always_comb begin
    err_d      = err_q;
    err_code_d = err_code_q;
    if (new_err_c && (!err_q || bus.clr_err)) begin
      err_d      = 1'b1;
      err_code_d = new_code_c;
    end else if (bus.clr_err) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      high_len_q     <= '0;
      low_len_q      <= '0;
      period_valid_q <= 1'b0;
      good_cnt_q     <= '0;
      locked_q       <= 1'b0;
      high_ok_q      <= 1'b0;
      err_q          <= 1'b0;
      err_code_q     <= ERR_NONE;
    end else begin
      cnt_q          <= cnt_d;
      high_len_q     <= high_len_d;
      low_len_q      <= low_len_d;
      period_valid_q <= period_valid_d;
      good_cnt_q     <= good_cnt_d;
      locked_q       <= locked_d;
      high_ok_q      <= high_ok_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
    end
  end

  assign bus.high_len     = high_len_q;
  assign bus.low_len      = low_len_q;
  assign bus.period_valid = period_valid_q;
  assign bus.locked       = locked_q;
  assign bus.err          = err_q;
  assign bus.err_code     = err_code_q;

endmodule

// File: tb/tb_clk_div_checker.sv
// Directed bench for clk_div_checker: clk_div is driven as explicit high/low phases
// and status {period_valid, locked, err, err_code} is checked at hand-derived cycles.
module tb_clk_div_checker;

  localparam int unsigned DIV          = 28;
  localparam int unsigned HIGH_CYC     = 14;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned LOCK_PERIODS = 2;

  logic clk_in = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  clk_div_checker_if #(.CNT_W(CNT_W)) bus ();

  clk_div_checker #(
    .DIV          (DIV),
    .HIGH_CYC     (HIGH_CYC),
    .CNT_W        (CNT_W),
    .LOCK_PERIODS (LOCK_PERIODS)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // {period_valid, locked, err, err_code}
  wire [4:0]  status = {bus.period_valid, bus.locked, bus.err, bus.err_code};
  wire [15:0] lens   = {bus.high_len, bus.low_len};

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic hi(input int n);
    bus.clk_div = 1'b1;
    cyc(n);
  endtask

  task automatic lo(input int n);
    bus.clk_div = 1'b0;
    cyc(n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.clk_div = 1'b0;
    bus.clr_err = 1'b0;
    cyc(3);
    checks++;
    if (status !== 5'b00000) begin
      errors++; $display("FAIL reset_status: got %b expected %b", status, 5'b00000);
    end
    checks++;
    if (lens !== 16'h0000) begin
      errors++; $display("FAIL reset_lens: got %h expected %h", lens, 16'h0000);
    end
    rst = 1'b0;
    cyc(2);
    checks++;
    if (status !== 5'b00000) begin
      errors++; $display("FAIL idle_after_reset: got %b expected %b", status, 5'b00000);
    end
  endtask

  task automatic test_lock();
    hi(14); lo(14); hi(2);
    checks++;
    if (status !== 5'b10000) begin
      errors++; $display("FAIL lock_p1_status: got %b expected %b", status, 5'b10000);
    end
    checks++;
    if (lens !== {8'd14, 8'd14}) begin
      errors++; $display("FAIL lock_p1_lens: got %h expected %h", lens, {8'd14, 8'd14});
    end
    cyc(1);
    checks++;
    if (status !== 5'b00000) begin
      errors++; $display("FAIL pv_one_cycle: got %b expected %b", status, 5'b00000);
    end
    hi(11); lo(14); hi(2);
    checks++;
    if (status !== 5'b11000) begin
      errors++; $display("FAIL lock_p2_status: got %b expected %b", status, 5'b11000);
    end
  endtask

  task automatic test_glitch_high();
    hi(11); lo(1);
    checks++;
    if (status !== 5'b01000) begin
      errors++; $display("FAIL glitch_before_fall: got %b expected %b", status, 5'b01000);
    end
    cyc(1);
    checks++;
    if (status !== 5'b00101) begin
      errors++; $display("FAIL glitch_at_fall: got %b expected %b", status, 5'b00101);
    end
    lo(12); hi(2);
    checks++;
    if (status !== 5'b10101) begin
      errors++; $display("FAIL glitch_period_status: got %b expected %b", status, 5'b10101);
    end
    checks++;
    if (lens !== {8'd13, 8'd14}) begin
      errors++; $display("FAIL glitch_period_lens: got %h expected %h", lens, {8'd13, 8'd14});
    end
    hi(12); lo(14); hi(2);
    checks++;
    if (status !== 5'b10101) begin
      errors++; $display("FAIL glitch_relock_1: got %b expected %b", status, 5'b10101);
    end
    hi(12); lo(14); hi(2);
    checks++;
    if (status !== 5'b11101) begin
      errors++; $display("FAIL glitch_relock_2: got %b expected %b", status, 5'b11101);
    end
  endtask

  task automatic test_clr_err();
    bus.clr_err = 1'b1;
    hi(1);
    bus.clr_err = 1'b0;
    checks++;
    if (status !== 5'b01000) begin
      errors++; $display("FAIL clr_alone: got %b expected %b", status, 5'b01000);
    end
    hi(11);
  endtask

  task automatic test_bad_low();
    lo(15); hi(2);
    checks++;
    if (status !== 5'b10110) begin
      errors++; $display("FAIL bad_low_status: got %b expected %b", status, 5'b10110);
    end
    checks++;
    if (lens !== {8'd14, 8'd15}) begin
      errors++; $display("FAIL bad_low_lens: got %h expected %h", lens, {8'd14, 8'd15});
    end
    hi(12); lo(14); hi(2);
    checks++;
    if (status !== 5'b10110) begin
      errors++; $display("FAIL bad_low_relock_1: got %b expected %b", status, 5'b10110);
    end
    hi(12); lo(14); hi(2);
    checks++;
    if (status !== 5'b11110) begin
      errors++; $display("FAIL bad_low_relock_2: got %b expected %b", status, 5'b11110);
    end
    bus.clr_err = 1'b1;
    hi(1);
    bus.clr_err = 1'b0;
    checks++;
    if (status !== 5'b01000) begin
      errors++; $display("FAIL bad_low_clear: got %b expected %b", status, 5'b01000);
    end
  endtask

  task automatic test_timeout();
    hi(26);
    checks++;
    if (status !== 5'b01000) begin
      errors++; $display("FAIL timeout_edge_minus1: got %b expected %b", status, 5'b01000);
    end
    hi(1);
    checks++;
    if (status !== 5'b00111) begin
      errors++; $display("FAIL timeout_fire: got %b expected %b", status, 5'b00111);
    end
    hi(10); lo(14);
    checks++;
    if (status !== 5'b00111) begin
      errors++; $display("FAIL timeout_idle_hold: got %b expected %b", status, 5'b00111);
    end
    hi(14); lo(14); hi(2);
    checks++;
    if (status !== 5'b10111) begin
      errors++; $display("FAIL timeout_resume_1: got %b expected %b", status, 5'b10111);
    end
    checks++;
    if (lens !== {8'd14, 8'd14}) begin
      errors++; $display("FAIL timeout_resume_lens: got %h expected %h", lens, {8'd14, 8'd14});
    end
    hi(12); lo(14); hi(2);
    checks++;
    if (status !== 5'b11111) begin
      errors++; $display("FAIL timeout_resume_2: got %b expected %b", status, 5'b11111);
    end
  endtask

  task automatic test_clr_with_error();
    hi(11); lo(1);
    bus.clr_err = 1'b1;
    cyc(1);
    bus.clr_err = 1'b0;
    checks++;
    if (status !== 5'b00101) begin
      errors++; $display("FAIL clr_vs_new_err: got %b expected %b", status, 5'b00101);
    end
    lo(12); hi(2);
    checks++;
    if (status !== 5'b10101) begin
      errors++; $display("FAIL clr_vs_new_err_period: got %b expected %b", status, 5'b10101);
    end
  endtask

  task automatic test_reset_mid();
    int pv_seen;
    hi(12); lo(14); hi(2);
    hi(12); lo(14); hi(2);
    checks++;
    if (status !== 5'b11101) begin
      errors++; $display("FAIL pre_reset_locked: got %b expected %b", status, 5'b11101);
    end
    hi(3);
    rst = 1'b1;
    #1;
    checks++;
    if (status !== 5'b00000) begin
      errors++; $display("FAIL mid_reset_status: got %b expected %b", status, 5'b00000);
    end
    checks++;
    if (lens !== 16'h0000) begin
      errors++; $display("FAIL mid_reset_lens: got %h expected %h", lens, 16'h0000);
    end
    hi(9); lo(5);
    rst = 1'b0;
    lo(9);
    pv_seen = 0;
    bus.clk_div = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cyc(1);
      if (bus.period_valid) pv_seen++;
    end
    bus.clk_div = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cyc(1);
      if (bus.period_valid) pv_seen++;
    end
    checks++;
    if (pv_seen !== 0) begin
      errors++; $display("FAIL early_pv_after_reset: got %0d expected %0d", pv_seen, 0);
    end
    hi(2);
    checks++;
    if (status !== 5'b10000) begin
      errors++; $display("FAIL first_pv_after_reset: got %b expected %b", status, 5'b10000);
    end
    checks++;
    if (lens !== {8'd14, 8'd14}) begin
      errors++; $display("FAIL first_lens_after_reset: got %h expected %h", lens, {8'd14, 8'd14});
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_glitch_high();
    test_clr_err();
    test_bad_low();
    test_timeout();
    test_clr_with_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
